mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Byte-serial memory stage: loads/stores move one byte per cycle through a
// synchronous 8-bit RAM port while the pipeline is stalled.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_store_data,
    input  logic [31:0]       ex_rd_data,
    input  logic [4:0]        ex_rd_addr,
    input  logic              ex_rd_enable,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              mem_stall,
    output logic [31:0]       mem_rd_data,
    output logic [4:0]        mem_rd_addr,
    output logic              mem_rd_enable
);

    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LBU = 4'd4, OP_LHU = 4'd5,
                           OP_SB = 4'd6, OP_SH = 4'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              tail_q, tail_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [4:0]        rdaddr_q, rdaddr_d;
    logic              rden_q, rden_d;
    logic [31:0]       buf_q, buf_d;

    logic       ex_is_mem, is_load;
    logic [1:0] last, cap_idx;

    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: last_idx = 2'd0;
            OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
            default:              last_idx = 2'd3;
        endcase
    endfunction

    assign ex_is_mem = ex_mem_op inside {[4'd1:4'd8]};
    assign is_load   = op_q inside {[4'd1:4'd5]};
    assign last      = last_idx(op_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tail_d        = tail_q;
        op_d          = op_q;
        base_d        = base_q;
        sdata_d       = sdata_q;
        rdaddr_d      = rdaddr_q;
        rden_d        = rden_q;
        buf_d         = buf_q;
        cap_idx       = 2'd0;
        ram_addr      = '0;
        ram_wdata     = '0;
        ram_we        = 1'b0;
        mem_stall     = 1'b0;
        mem_rd_data   = '0;
        mem_rd_addr   = '0;
        mem_rd_enable = 1'b0;
        case (state_q)
            IDLE: begin
                // rst gates the combinational paths so reset silences outputs at once
                if (ex_valid && rst) begin
                    if (ex_is_mem) begin
                        mem_stall = 1'b1;
                        op_d      = ex_mem_op;
                        base_d    = ex_addr;
                        sdata_d   = ex_store_data;
                        rdaddr_d  = ex_rd_addr;
                        rden_d    = ex_rd_enable;
                        buf_d     = '0;
                        cnt_d     = 2'd0;
                        tail_d    = 1'b0;
                        state_d   = BUSY;
                    end else begin
                        mem_rd_data   = ex_rd_data;
                        mem_rd_addr   = ex_rd_addr;
                        mem_rd_enable = ex_rd_enable;
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (!tail_q) begin
                    ram_addr = base_q + ADDR_W'(cnt_q);
                    if (!is_load) begin
                        ram_we    = 1'b1;
                        ram_wdata = sdata_q[{cnt_q, 3'b000} +: 8];
                    end
                end
                // read data trails the address by one cycle; the tail cycle takes the last byte
                if (is_load && (tail_q || cnt_q != 2'd0)) begin
                    cap_idx = tail_q ? last : cnt_q - 2'd1;
                    buf_d[{cap_idx, 3'b000} +: 8] = ram_rdata;
                end
                if (tail_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last) begin
                        if (is_load) tail_d  = 1'b1;
                        else         state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (is_load) begin
                    case (op_q)
                        OP_LB:   mem_rd_data = {{24{buf_q[7]}}, buf_q[7:0]};
                        OP_LBU:  mem_rd_data = {24'b0, buf_q[7:0]};
                        OP_LH:   mem_rd_data = {{16{buf_q[15]}}, buf_q[15:0]};
                        OP_LHU:  mem_rd_data = {16'b0, buf_q[15:0]};
                        default: mem_rd_data = buf_q;
                    endcase
                    mem_rd_addr   = rdaddr_q;
                    mem_rd_enable = rden_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tail_q   <= 1'b0;
            op_q     <= '0;
            base_q   <= '0;
            sdata_q  <= '0;
            rdaddr_q <= '0;
            rden_q   <= 1'b0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            op_q     <= op_d;
            base_q   <= base_d;
            sdata_q  <= sdata_d;
            rdaddr_q <= rdaddr_d;
            rden_q   <= rden_d;
            buf_q    <= buf_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural synchronous byte RAM.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr, ex_store_data, ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_enable;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        mem_stall;
    logic [31:0] mem_rd_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_enable;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd_data(ex_rd_data),
        .ex_rd_addr(ex_rd_addr), .ex_rd_enable(ex_rd_enable),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .mem_stall(mem_stall), .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr),
        .mem_rd_enable(mem_rd_enable)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[9:0]];
    end

    int alu_seen = 0;
    always @(negedge clk) if (rst && mem_rd_enable && mem_rd_addr == 5'd9) alu_seen++;

    int passed = 0, total = 0;
    logic [31:0] alog [0:15];
    logic [7:0]  dlog [0:15];
    logic        wlog [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Accept an op in a fresh IDLE cycle, follow it to DONE, check latency and result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input int exp_lat,
                          input logic [31:0] exp_data, input logic is_ld);
        int   lat;
        logic bad;
        cyc;
        ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr; ex_store_data = sdata;
        ex_rd_addr = rd; ex_rd_enable = 1'b1; ex_rd_data = 32'hDEAD0000;
        #1;
        chk({tag, "_acc_stall"}, 32'(mem_stall), 32'd1);
        chk({tag, "_acc_en"}, 32'(mem_rd_enable), 32'd0);
        lat = 0;
        bad = 1'b0;
        do begin
            cyc;
            lat++;
            alog[lat-1] = ram_addr;
            dlog[lat-1] = ram_wdata;
            wlog[lat-1] = ram_we;
            if (mem_stall && mem_rd_enable) bad = 1'b1;
            if (lat == 1) begin
                ex_mem_op = op ^ 4'h3; ex_addr = addr ^ 32'h55;
                ex_store_data = ~sdata; ex_rd_addr = rd ^ 5'h1F;
            end
        end while (mem_stall && lat < 12);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stall_en"}, 32'(bad), 32'd0);
        chk({tag, "_done_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_done_en"}, 32'(mem_rd_enable), 32'(is_ld));
        if (is_ld) begin
            chk({tag, "_data"}, mem_rd_data, exp_data);
            chk({tag, "_rd"}, 32'(mem_rd_addr), 32'(rd));
        end
        ex_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[10'h000] = 8'h33; mem[10'h001] = 8'h44;
        rst = 1'b0; ex_valid = 1'b1; ex_mem_op = 4'd8; ex_addr = 32'h100;
        ex_store_data = 0; ex_rd_data = 0; ex_rd_addr = 0; ex_rd_enable = 1'b1;
        #2;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_en", 32'(mem_rd_enable), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", ram_addr, 32'd0);

        cyc;
        rst = 1'b1; ex_valid = 1'b0;
        #1;
        chk("idle_en", 32'(mem_rd_enable), 32'd0);
        chk("idle_stall", 32'(mem_stall), 32'd0);

        ex_valid = 1'b1; ex_mem_op = 4'd0; ex_rd_data = 32'h12345678; ex_rd_addr = 5'd5;
        ex_rd_enable = 1'b1;
        #1;
        chk("alu_data", mem_rd_data, 32'h12345678);
        chk("alu_rd", 32'(mem_rd_addr), 32'd5);
        chk("alu_en", 32'(mem_rd_enable), 32'd1);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        ex_mem_op = 4'd12; ex_rd_data = 32'hCAFEF00D;
        #1;
        chk("op12_data", mem_rd_data, 32'hCAFEF00D);
        chk("op12_stall", 32'(mem_stall), 32'd0);
        cyc;
        chk("op12_next_stall", 32'(mem_stall), 32'd0);
        ex_valid = 1'b0;

        run_op("SW", 4'd8, 32'h100, 32'hA1B2C3D4, 5'd3, 5, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("SW_addr%0d", k), alog[k], 32'h100 + 32'(k));
            chk($sformatf("SW_we%0d", k), 32'(wlog[k]), 32'd1);
        end
        chk("SW_wd0", 32'(dlog[0]), 32'hD4);
        chk("SW_wd3", 32'(dlog[3]), 32'hA1);
        chk("SW_mem", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]}, 32'hA1B2C3D4);

        run_op("LB", 4'd1, 32'h103, 32'h0, 5'd7, 3, 32'hFFFFFFA1, 1'b1);
        chk("LB_addr", alog[0], 32'h103);
        chk("LB_we", 32'(wlog[0]), 32'd0);
        run_op("LBU", 4'd4, 32'h103, 32'h0, 5'd7, 3, 32'h000000A1, 1'b1);
        run_op("LH", 4'd2, 32'h102, 32'h0, 5'd8, 4, 32'hFFFFA1B2, 1'b1);
        run_op("SH", 4'd7, 32'h200, 32'h1234BEEF, 5'd2, 3, 32'h0, 1'b0);
        chk("SH_mem", {8'h00, mem[10'h202], mem[10'h201], mem[10'h200]}, 32'h0000BEEF);
        run_op("LHmis", 4'd2, 32'h1FF, 32'h0, 5'd6, 4, 32'hFFFFEF00, 1'b1);
        run_op("LHU", 4'd5, 32'h200, 32'h0, 5'd6, 4, 32'h0000BEEF, 1'b1);

        base = alu_seen;
        run_op("LWwrap", 4'd3, 32'hFFFFFFFE, 32'h0, 5'd4, 6, 32'h44332211, 1'b1);
        chk("LWwrap_a0", alog[0], 32'hFFFFFFFE);
        chk("LWwrap_a1", alog[1], 32'hFFFFFFFF);
        chk("LWwrap_a2", alog[2], 32'h00000000);
        chk("LWwrap_a3", alog[3], 32'h00000001);
        cyc;
        ex_valid = 1'b1; ex_mem_op = 4'd0; ex_rd_data = 32'h0BADBEEF; ex_rd_addr = 5'd9;
        ex_rd_enable = 1'b1;
        #1;
        chk("b2b_en", 32'(mem_rd_enable), 32'd1);
        chk("b2b_data", mem_rd_data, 32'h0BADBEEF);
        cyc;
        ex_valid = 1'b0;
        cyc;
        chk("b2b_once", 32'(alu_seen - base), 32'd1);

        ex_valid = 1'b1; ex_mem_op = 4'd8; ex_addr = 32'h100; ex_store_data = 32'h55667788;
        ex_rd_addr = 5'd1;
        #1;
        chk("rstmid_acc", 32'(mem_stall), 32'd1);
        cyc;
        chk("rstmid_we1", 32'(ram_we), 32'd1);
        cyc;
        chk("rstmid_we2", 32'(ram_we), 32'd1);
        chk("rstmid_a2", ram_addr, 32'h101);
        cyc;
        rst = 1'b0;
        #1;
        chk("rstmid_we_drop", 32'(ram_we), 32'd0);
        chk("rstmid_stall", 32'(mem_stall), 32'd0);
        chk("rstmid_addr", ram_addr, 32'd0);
        chk("rstmid_mem", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]}, 32'hA1B27788);
        cyc;
        rst = 1'b1; ex_valid = 1'b0;
        run_op("LWpost", 4'd3, 32'h100, 32'h0, 5'd10, 6, 32'hA1B27788, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
